// File: rtl/upstream_link_sched.sv
`default_nettype none
// ============================================================================
// upstream_link_sched: two-requester round-robin 64-to-32 link scheduler with
// credit-based flow control.           Revision: 1.0
// ============================================================================
module upstream_link_sched #(
    parameter int CREDITS       = 16,
    parameter int TOKEN_CREDITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    input  logic [63:0] req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [63:0] req1_data_i,
    output logic        req1_ready_o,
    input  logic        token_i,
    output logic        link_valid_o,
    output logic [31:0] link_data_o,
    input  logic        link_ready_i,
    output logic        grant_o,
    output logic [6:0]  credit_o,
    output logic [6:0]  sent_cnt_o,
    output logic        error_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } state_t;

    localparam logic [6:0] C_CREDITS  = 7'(CREDITS);
    localparam logic [7:0] C_CREDITS8 = 8'(CREDITS);
    localparam logic [7:0] C_TOKEN    = 8'(TOKEN_CREDITS);

    state_t      state_q, state_d;
    logic [63:0] word_q, word_d;
    logic        grant_q, grant_d;
    logic        ptr_q, ptr_d;
    logic [6:0]  credit_q, credit_d;
    logic [6:0]  sent_q, sent_d;
    logic        error_q, error_d;

    logic        w_can;
    logic        w_win;
    logic        w_accept;
    logic        w_beat;
    logic [7:0]  w_sum;

    // The pointer only decides ties; with neither valid it still names the
    // requester whose ready is offered.
    assign w_can    = (state_q == S_IDLE) && (credit_q >= 7'd2);
    assign w_win    = (req0_valid_i == req1_valid_i) ? ptr_q : req1_valid_i;
    assign w_accept = w_can && (req0_valid_i || req1_valid_i);
    assign w_beat   = link_valid_o && link_ready_i;

    assign req0_ready_o = !rst && w_can && !w_win;
    assign req1_ready_o = !rst && w_can && w_win;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        error_d  = error_q;
        sent_d   = sent_q + {6'd0, w_beat};
        w_sum    = {1'b0, credit_q} - {7'd0, w_beat} + (token_i ? C_TOKEN : 8'd0);
        credit_d = w_sum[6:0];

        if (w_sum > C_CREDITS8) begin
            credit_d = C_CREDITS;
            error_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_BEAT0;
                    word_d  = w_win ? req1_data_i : req0_data_i;
                    grant_d = w_win;
                    ptr_d   = ~w_win;
                end
            end
            S_BEAT0: begin
                if (link_ready_i) begin
                    state_d = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (link_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            word_q   <= 64'd0;
            grant_q  <= 1'b0;
            ptr_q    <= 1'b0;
            credit_q <= C_CREDITS;
            sent_q   <= 7'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            sent_q   <= sent_d;
            error_q  <= error_d;
        end
    end

    assign link_valid_o = (state_q != S_IDLE);
    assign link_data_o  = (state_q == S_BEAT0) ? word_q[31:0]  :
                          (state_q == S_BEAT1) ? word_q[63:32] : 32'd0;
    assign grant_o      = grant_q;
    assign credit_o     = credit_q;
    assign sent_cnt_o   = sent_q;
    assign error_o      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_upstream_link_sched.sv
`default_nettype none
// ============================================================================
// tb_upstream_link_sched: scoreboard bench for upstream_link_sched against a
// queue-based reference model.          Revision: 1.0
// ============================================================================
module tb_upstream_link_sched;

    localparam int CREDITS       = 16;
    localparam int TOKEN_CREDITS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid_i = 1'b0;
    logic [63:0] req0_data_i  = 64'd0;
    logic        req0_ready_o;
    logic        req1_valid_i = 1'b0;
    logic [63:0] req1_data_i  = 64'd0;
    logic        req1_ready_o;
    logic        token_i = 1'b0;
    logic        link_valid_o;
    logic [31:0] link_data_o;
    logic        link_ready_i = 1'b0;
    logic        grant_o;
    logic [6:0]  credit_o;
    logic [6:0]  sent_cnt_o;
    logic        error_o;

    upstream_link_sched #(.CREDITS(CREDITS), .TOKEN_CREDITS(TOKEN_CREDITS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .token_i(token_i),
        .link_valid_o(link_valid_o), .link_data_o(link_data_o), .link_ready_i(link_ready_i),
        .grant_o(grant_o), .credit_o(credit_o), .sent_cnt_o(sent_cnt_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        grant;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_beats[$];
    int          m_credit;
    int          m_sent;
    bit          m_err;
    bit          m_ptr;
    bit          m_grant;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_beats.delete();
        m_credit = CREDITS;
        m_sent   = 0;
        m_err    = 1'b0;
        m_ptr    = 1'b0;
        m_grant  = 1'b0;
    endtask

    // Caller chooses when rst rises; it is released on a later falling edge.
    task automatic do_reset();
        rst          = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        token_i      = 1'b0;
        link_ready_i = 1'b0;
        #1;
        chk("rst_link_valid", link_valid_o, 0);
        chk("rst_ready0", req0_ready_o, 0);
        chk("rst_ready1", req1_ready_o, 0);
        chk("rst_credit", credit_o, CREDITS);
        chk("rst_sent", sent_cnt_o, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit v0, input logic [63:0] d0, input bit v1,
                        input logic [63:0] d1, input bit tok, input bit lr);
        bit          idle, can, win, acc, beat;
        int          c;
        logic [63:0] d;
        @(negedge clk);
        chk("credit", credit_o, m_credit);
        chk("sent_cnt", sent_cnt_o, m_sent);
        chk("error", error_o, m_err);
        chk("link_valid", link_valid_o, m_beats.size() != 0);
        chk("link_data", link_data_o, (m_beats.size() != 0) ? m_beats[0] : 32'd0);
        if (m_beats.size() != 0) chk("grant", grant_o, m_grant);
        req0_valid_i = v0; req0_data_i = d0;
        req1_valid_i = v1; req1_data_i = d1;
        token_i      = tok;
        link_ready_i = lr;
        #1;
        idle = (m_beats.size() == 0);
        can  = idle && (m_credit >= 2);
        win  = (v0 && v1) ? m_ptr : v1;
        acc  = can && (v0 || v1);
        if (v0 || v1) begin
            chk("ready0", req0_ready_o, can && !win);
            chk("ready1", req1_ready_o, can && win);
        end else begin
            chk("ready_exclusive", req0_ready_o & req1_ready_o, 0);
        end
        if (acc) begin
            exp_t e;
            d = win ? d1 : d0;
            m_beats.push_back(d[31:0]);
            m_beats.push_back(d[63:32]);
            e.grant = win;
            e.data  = d[31:0];  exp_q.push_back(e);
            e.data  = d[63:32]; exp_q.push_back(e);
            m_grant = win;
            m_ptr   = !win;
        end
        beat = !idle && lr;
        if (beat) begin
            void'(m_beats.pop_front());
            m_sent = (m_sent + 1) % 128;
        end
        c = m_credit - (beat ? 1 : 0) + (tok ? TOKEN_CREDITS : 0);
        if (c > CREDITS) begin
            c     = CREDITS;
            m_err = 1'b1;
        end
        m_credit = c;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: every transferred beat must match the oldest expected beat.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && link_valid_o && link_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected actual=%0h expected=none", link_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", link_data_o, e.data);
                    chk("beat_grant", grant_o, e.grant);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #2;
        do_reset();
        chk("reset_credit", credit_o, 16);
        chk("reset_grant", grant_o, 0);
        chk("reset_error", error_o, 0);

        // Single word from requester 0.
        step(1, 64'h1122334455667788, 0, 0, 0, 1);
        idle_steps(3);
        chk("word_credit", credit_o, 14);
        chk("word_sent", sent_cnt_o, 2);

        // Both requesters valid: grants alternate.
        for (int i = 0; i < 12; i++)
            step(1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 0, 1);
        idle_steps(3);

        // Credit starvation, then one token releases the ninth word.
        do_reset();
        for (int i = 0; i < 30; i++) step(1, {$urandom, $urandom}, 0, 0, 0, 1);
        chk("starve_credit", credit_o, 0);
        chk("starve_ready0", req0_ready_o, 0);
        step(1, 64'hCAFEF00D_DEADBEEF, 0, 0, 1, 1);
        @(posedge clk); #1;
        chk("token_credit", credit_o, 8);
        step(1, 64'hCAFEF00D_DEADBEEF, 0, 0, 0, 1);
        idle_steps(3);

        // Downstream stall in the second beat.
        step(0, 0, 1, 64'hA5A5A5A5_5A5A5A5A, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        idle_steps(3);

        // Token at full credit overflows.
        do_reset();
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("ovf_full_credit", credit_o, 16);
        chk("ovf_full_error", error_o, 1);

        // Token together with a beat at credit 10 saturates.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, {$urandom, $urandom}, 0, 0, 0, 1);
        step(1, {$urandom, $urandom}, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("ovf_beat_credit", credit_o, 16);
        chk("ovf_beat_error", error_o, 1);
        idle_steps(2);

        // Reset asserted while the first beat is stalled.
        step(1, 64'h01234567_89ABCDEF, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        #2;
        do_reset();
        chk("midrst_error", error_o, 0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 1), {$urandom, $urandom},
                 $urandom_range(0, 1), {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        idle_steps(5);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/upstream_link_sched.md
UPSTREAM_LINK_SCHED -- requirements
Module: upstream_link_sched

Interface
REQ-001 Parameter CREDITS, default 16: initial and maximum link credits, each credit one 32-bit beat; legal range 2..64.
REQ-002 Parameter TOKEN_CREDITS, default 8: credits returned per token pulse.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0_valid_i  in  1  requester 0 has a 64-bit word.
REQ-006 req0_data_i  in  64  requester 0 word.
REQ-007 req0_ready_o  out  1  requester 0 word accepted this cycle when valid is also high.
REQ-008 req1_valid_i / req1_data_i / req1_ready_o  in/in/out  1/64/1  requester 1, same semantics.
REQ-009 token_i  in  1  single-cycle credit-return pulse, already synchronized to clk.
REQ-010 link_valid_o  out  1  beat present on link_data_o.
REQ-011 link_data_o  out  32  beat data.
REQ-012 link_ready_i  in  1  downstream PISO accepts beat.
REQ-013 grant_o  out  1  requester owning the word in flight (0/1).
REQ-014 credit_o  out  7  current credit count.
REQ-015 sent_cnt_o  out  7  beats transferred, modulo 128.
REQ-016 error_o  out  1  sticky credit-overflow flag.

Function
REQ-017 FSM states IDLE, BEAT0, BEAT1, registered.
REQ-018 IDLE: accept a word when credit_o >= 2 and at least one valid high; go to BEAT0 next cycle.
REQ-019 Credits below 2 in IDLE: both ready outputs low, stay IDLE; no partial word issued.
REQ-020 ready outputs combinational: high only in IDLE, credit_o >= 2, for granted requester only; never both high.
REQ-021 Arbitration round-robin: one valid wins; both valid -> priority pointer requester wins; pointer flips to other requester after every accepted word.
REQ-022 Priority pointer reset value selects requester 0.
REQ-023 Accepted word and winner index registered on acceptance; grant_o holds the index until return to IDLE.
REQ-024 BEAT0: link_valid_o=1, link_data_o=word[31:0]; link_ready_i high -> BEAT1, else hold.
REQ-025 BEAT1: link_valid_o=1, link_data_o=word[63:32]; link_ready_i high -> IDLE, else hold.
REQ-026 link_data_o stable while link_valid_o high and link_ready_i low.
REQ-027 IDLE: link_valid_o=0, link_data_o=0.
REQ-028 Minimum word period 3 cycles: one IDLE bubble between words.
REQ-029 Credit update per cycle: credit_next = credit - beat + (token_i ? TOKEN_CREDITS : 0), beat = link_valid_o & link_ready_i; simultaneous beat and token both apply.
REQ-030 credit_next > CREDITS: credit saturates at CREDITS, error_o set, held until reset.
REQ-031 Credit never underflows: acceptance rule (REQ-018) reserves both beats of a word.
REQ-032 sent_cnt_o increments by 1 per beat, wraps 127 -> 0.
REQ-033 Internal widths 7 bits; arithmetic in 8 bits before saturation compare.

Reset
REQ-034 rst asserted asynchronously forces: state IDLE, credit_o=CREDITS, sent_cnt_o=0, error_o=0, grant_o=0, pointer=0, word register 0, link_valid_o=0, ready outputs 0.
REQ-035 rst mid-word aborts the word without completing remaining beats; no credit restored for beats already sent beyond reset value.
REQ-036 First acceptance possible in the first clk edge after rst deasserts.

Verification
REQ-037 Reset, req0 valid with 0x1122334455667788, ready high -> beats 0x55667788 then 0x11223344 on cycles 2,3; credit_o 16->14; sent_cnt_o=2.
REQ-038 Both requesters continuously valid, ready high -> grants alternate 0,1,0,1; each word 3 cycles.
REQ-039 No tokens, 9 words requested -> 8 words sent, credit_o=0, ready outputs stay low; one token_i -> credit_o=8, ninth word issues.
REQ-040 link_ready_i low 5 cycles in BEAT1 -> link_valid_o and link_data_o held, credit unchanged until accepted.
REQ-041 token_i with credit_o=16 -> credit_o stays 16, error_o=1 until rst; token and beat same cycle at credit 10 -> 17 saturates? no: 10-1+8=17 -> credit 16, error_o=1.
REQ-042 rst asserted during BEAT0 -> link_valid_o low immediately, credit_o=16, sent_cnt_o=0.
